// File: rtl/easy_fifo_pkg.sv
// Shared types and the round-robin search used by the AXIS arbiter.
// rr_pick scans up to 16 requesters starting at ptr and wrapping at n.
package easy_fifo_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   localparam int unsigned RR_MAX_SRC = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_pick_t;

   function automatic rr_pick_t rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                        input logic [3:0]            ptr,
                                        input int unsigned           n);
      rr_pick_t    res;
      int unsigned j;
      res = '0;
      for (int unsigned k = 0; k < RR_MAX_SRC; k++) begin
         // ptr < n, so one subtraction is enough to wrap
         j = 32'(ptr) + k;
         if (j >= n) j = j - n;
         if (!res.found && (k < n) && req[j[3:0]]) begin
            res.found = 1'b1;
            res.idx   = j[3:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/easy_fifo_axis_rr_arb_if.sv
// AXI-Stream bundle for the N-to-1 arbiter: N source channels in, one tagged channel out.
// slave is the arbiter's view; master is the view of whatever drives sources and sinks.
interface easy_fifo_axis_rr_arb_if #(
   parameter int DWIDTH = 32,
   parameter int N_SRC  = 4
);
   localparam int IDW = $clog2(N_SRC);

   logic [N_SRC*DWIDTH-1:0] s_axis_tdata;
   logic [N_SRC-1:0]        s_axis_tvalid;
   logic [N_SRC-1:0]        s_axis_tlast;
   logic [N_SRC-1:0]        s_axis_tready;
   logic [DWIDTH-1:0]       m_axis_tdata;
   logic                    m_axis_tvalid;
   logic                    m_axis_tlast;
   logic [IDW-1:0]          m_axis_tid;
   logic                    m_axis_tready;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
   );

endinterface

// File: rtl/easy_fifo_axis_out_reg.sv
// Single-entry registered AXIS slot (data, last, tid, valid).
// slot_free_o says a new beat may be loaded this cycle.
module easy_fifo_axis_out_reg #(
   parameter int DWIDTH = 32,
   parameter int IDW    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              last_i,
   input  logic [IDW-1:0]    tid_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DWIDTH-1:0] data_o,
   output logic              last_o,
   output logic [IDW-1:0]    tid_o,
   output logic              slot_free_o
);

   logic              valid_q;
   logic [DWIDTH-1:0] data_q;
   logic              last_q;
   logic [IDW-1:0]    tid_q;

   assign slot_free_o = ~valid_q | ready_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         tid_q   <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         last_q  <= last_i;
         tid_q   <= tid_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;
   assign tid_o   = tid_q;

endmodule

// File: rtl/easy_fifo_axis_rr_arb.sv
// Packet-atomic N-to-1 AXIS arbiter feeding one registered output slot.
// A grant is held from arbitration until the granted source's tlast beat is accepted.
//
//   state    | meaning
//   ARB_IDLE | no grant; choose a winner among valid sources
//   ARB_LOCK | grant held; forward beats from the granted source
module easy_fifo_axis_rr_arb
   import easy_fifo_pkg::*;
#(
   parameter  int DWIDTH      = 32,
   parameter  int N_SRC       = 4,
   parameter  int ROUND_ROBIN = 1,
   localparam int IDW         = $clog2(N_SRC)
) (
   input  logic                    clk,
   input  logic                    rst,
   easy_fifo_axis_rr_arb_if.slave  axis,
   output logic                    busy
);

   arb_state_t        state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    grant_q, grant_d;
   logic [N_SRC-1:0]  tready;
   logic              slot_free;
   logic              load;
   rr_pick_t          pick;

   logic [DWIDTH-1:0] g_data;
   logic              g_valid;
   logic              g_last;

   logic              m_valid;
   logic [DWIDTH-1:0] m_data;
   logic              m_last;
   logic [IDW-1:0]    m_tid;

   assign g_data  = axis.s_axis_tdata[grant_q*DWIDTH +: DWIDTH];
   assign g_valid = axis.s_axis_tvalid[grant_q];
   assign g_last  = axis.s_axis_tlast[grant_q];

   // fixed priority is the same search anchored at index 0
   assign pick = rr_pick(RR_MAX_SRC'(axis.s_axis_tvalid),
                         (ROUND_ROBIN != 0) ? 4'(ptr_q) : 4'd0,
                         N_SRC);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      tready  = '0;
      load    = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick.found) begin
               grant_d = IDW'(pick.idx);
               state_d = ARB_LOCK;
            end
         end
         ARB_LOCK: begin
            tready[grant_q] = slot_free;
            if (g_valid && slot_free) begin
               load = 1'b1;
               if (g_last) begin
                  state_d = ARB_IDLE;
                  ptr_d   = (grant_q == IDW'(N_SRC-1)) ? '0 : grant_q + IDW'(1);
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   easy_fifo_axis_out_reg #(
      .DWIDTH (DWIDTH),
      .IDW    (IDW)
   ) u_out_reg (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load),
      .data_i      (g_data),
      .last_i      (g_last),
      .tid_i       (grant_q),
      .ready_i     (axis.m_axis_tready),
      .valid_o     (m_valid),
      .data_o      (m_data),
      .last_o      (m_last),
      .tid_o       (m_tid),
      .slot_free_o (slot_free)
   );

   assign axis.s_axis_tready = tready;
   assign axis.m_axis_tvalid = m_valid;
   assign axis.m_axis_tdata  = m_data;
   assign axis.m_axis_tlast  = m_last;
   assign axis.m_axis_tid    = m_tid;
   assign busy               = (state_q == ARB_LOCK);

endmodule

// File: tb/tb_easy_fifo_axis_rr_arb.sv
// Bench for the packet-atomic AXIS arbiter: a round-robin and a fixed-priority instance
// share one source driver; per-source packet queues form the reference for the output stream.
module tb_easy_fifo_axis_rr_arb;

   localparam int DW  = 32;
   localparam int NS  = 4;
   localparam int IDW = $clog2(NS);

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            pre_gap;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   easy_fifo_axis_rr_arb_if #(.DWIDTH(DW), .N_SRC(NS)) rr_if ();
   easy_fifo_axis_rr_arb_if #(.DWIDTH(DW), .N_SRC(NS)) fp_if ();
   logic busy_rr, busy_fp;

   easy_fifo_axis_rr_arb #(.DWIDTH(DW), .N_SRC(NS), .ROUND_ROBIN(1)) u_rr (
      .clk(clk), .rst(rst), .axis(rr_if), .busy(busy_rr));
   easy_fifo_axis_rr_arb #(.DWIDTH(DW), .N_SRC(NS), .ROUND_ROBIN(0)) u_fp (
      .clk(clk), .rst(rst), .axis(fp_if), .busy(busy_fp));

   // sel=0 drives the round-robin instance, sel=1 the fixed-priority one
   logic              sel;
   logic [NS*DW-1:0]  drv_data;
   logic [NS-1:0]     drv_vld, drv_last;
   logic              drv_mrdy;

   assign rr_if.s_axis_tdata  = sel ? '0 : drv_data;
   assign rr_if.s_axis_tvalid = sel ? '0 : drv_vld;
   assign rr_if.s_axis_tlast  = sel ? '0 : drv_last;
   assign rr_if.m_axis_tready = sel ? 1'b1 : drv_mrdy;
   assign fp_if.s_axis_tdata  = sel ? drv_data : '0;
   assign fp_if.s_axis_tvalid = sel ? drv_vld : '0;
   assign fp_if.s_axis_tlast  = sel ? drv_last : '0;
   assign fp_if.m_axis_tready = sel ? drv_mrdy : 1'b1;

   logic [NS-1:0]  obs_trdy;
   logic [DW-1:0]  obs_tdata;
   logic           obs_mvalid, obs_mlast, obs_busy;
   logic [IDW-1:0] obs_tid;
   assign obs_trdy   = sel ? fp_if.s_axis_tready : rr_if.s_axis_tready;
   assign obs_tdata  = sel ? fp_if.m_axis_tdata  : rr_if.m_axis_tdata;
   assign obs_mvalid = sel ? fp_if.m_axis_tvalid : rr_if.m_axis_tvalid;
   assign obs_mlast  = sel ? fp_if.m_axis_tlast  : rr_if.m_axis_tlast;
   assign obs_tid    = sel ? fp_if.m_axis_tid    : rr_if.m_axis_tid;
   assign obs_busy   = sel ? busy_fp : busy_rr;

   int checks   = 0;
   int failures = 0;

   beat_t drv_q [NS][$];
   beat_t exp_q [NS][$];
   int    gap_cnt    [NS];
   bit    gap_loaded [NS];
   int    mode;
   bit    chk_timing;
   int    cyc;
   bit    in_pkt, have_prev, prev_hold;
   int    cur_tid, last_fire_cyc, beats_out, pkt_cnt;
   logic [63:0]    pkt_code;
   logic [DW-1:0]  hold_data;
   logic           hold_last;
   logic [IDW-1:0] hold_tid;

   task automatic reset_model();
      for (int i = 0; i < NS; i++) begin
         drv_q[i].delete();
         exp_q[i].delete();
         gap_loaded[i] = 1'b0;
         gap_cnt[i]    = 0;
      end
      drv_vld = '0; drv_last = '0; drv_data = '0;
      in_pkt = 0; have_prev = 0; prev_hold = 0;
      beats_out = 0; pkt_cnt = 0; pkt_code = '0;
   endtask

   task automatic push_pkt(input int src, input int len, input logic [DW-1:0] base,
                           input bit rnd_data, input int gap_at, input int gap_len,
                           input int max_rnd_gap);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data    = rnd_data ? DW'($urandom) : base + DW'(k);
         b.last    = (k == len - 1);
         b.pre_gap = (k == gap_at) ? gap_len :
                     ((max_rnd_gap > 0) ? int'($urandom_range(max_rnd_gap, 0)) : 0);
         drv_q[src].push_back(b);
         exp_q[src].push_back(b);
      end
   endtask

   task automatic drive_inputs();
      beat_t h;
      for (int i = 0; i < NS; i++) begin
         if (drv_q[i].size() == 0) begin
            drv_vld[i] = 1'b0;
         end else begin
            h = drv_q[i][0];
            if (!gap_loaded[i]) begin
               gap_cnt[i]    = h.pre_gap;
               gap_loaded[i] = 1'b1;
            end
            if (gap_cnt[i] > 0) begin
               drv_vld[i] = 1'b0;
               gap_cnt[i]--;
            end else begin
               drv_vld[i]             = 1'b1;
               drv_data[i*DW +: DW]   = h.data;
               drv_last[i]            = h.last;
            end
         end
      end
      case (mode)
         0:       drv_mrdy = 1'b1;
         1:       drv_mrdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         default: drv_mrdy = ($urandom_range(3, 0) != 0);
      endcase
   endtask

   // one clock: observe at negedge against the queues, then advance sources after posedge
   task automatic step();
      logic [NS-1:0] acc;
      beat_t e;
      int t;
      @(negedge clk);
      acc = drv_vld & obs_trdy;
      checks++;
      if ($countones(obs_trdy) > 1) begin
         failures++;
         $display("FAIL tready_onehot: got %b, required at most one bit set", obs_trdy);
      end
      if (prev_hold) begin
         checks++;
         if (obs_mvalid !== 1'b1 || obs_tdata !== hold_data || obs_tlast_ok() == 0 ||
             obs_tid !== hold_tid) begin
            failures++;
            $display("FAIL hold_stable: got v=%b d=%h l=%b id=%0d, required v=1 d=%h l=%b id=%0d",
                     obs_mvalid, obs_tdata, obs_mlast, obs_tid, hold_data, hold_last, hold_tid);
         end
      end
      if (obs_mvalid === 1'b1 && drv_mrdy === 1'b1) begin
         t = int'(obs_tid);
         beats_out++;
         checks++;
         if (exp_q[t].size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected: got tid=%0d data=%h, required no beat", t, obs_tdata);
         end else begin
            e = exp_q[t].pop_front();
            if (obs_tdata !== e.data || obs_mlast !== e.last) begin
               failures++;
               $display("FAIL beat_data: tid=%0d got d=%h l=%b, required d=%h l=%b",
                        t, obs_tdata, obs_mlast, e.data, e.last);
            end
         end
         if (in_pkt) begin
            checks++;
            if (t != cur_tid) begin
               failures++;
               $display("FAIL interleave: got tid=%0d, required tid=%0d", t, cur_tid);
            end
            if (chk_timing) begin
               checks++;
               if (cyc - last_fire_cyc != 1) begin
                  failures++;
                  $display("FAIL contiguous: got spacing %0d, required 1", cyc - last_fire_cyc);
               end
            end
         end else begin
            pkt_code = {pkt_code[59:0], 4'(t)};
            pkt_cnt++;
            if (chk_timing && have_prev) begin
               checks++;
               if (cyc - last_fire_cyc != 2) begin
                  failures++;
                  $display("FAIL bubble: got spacing %0d, required 2", cyc - last_fire_cyc);
               end
            end
         end
         in_pkt        = (obs_mlast !== 1'b1);
         cur_tid       = t;
         last_fire_cyc = cyc;
         have_prev     = 1'b1;
      end
      prev_hold = (obs_mvalid === 1'b1) && (drv_mrdy !== 1'b1);
      hold_data = obs_tdata;
      hold_last = obs_mlast;
      hold_tid  = obs_tid;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NS; i++) begin
         if (acc[i]) begin
            e = drv_q[i].pop_front();
            gap_loaded[i] = 1'b0;
         end
      end
      drive_inputs();
   endtask

   function automatic bit obs_tlast_ok();
      return obs_mlast === hold_last;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NS; i++)
         if (drv_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
      return obs_mvalid !== 1'b1;
   endfunction

   task automatic drain(input int budget);
      int n = 0;
      while (!all_empty() && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (!all_empty()) begin
         failures++;
         $display("FAIL drain_timeout: got pending traffic after %0d cycles, required empty", budget);
      end
   endtask

   task automatic test_reset();
      sel = 1'b0; mode = 0; drv_mrdy = 1'b1; chk_timing = 1'b0;
      reset_model();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checks++;
         if ({obs_mvalid, obs_mlast, obs_tdata, obs_tid, obs_trdy, obs_busy} !== '0) begin
            failures++;
            $display("FAIL reset_state: inst=%0d got v=%b l=%b d=%h id=%0d rdy=%b busy=%b, required all 0",
                     s, obs_mvalid, obs_mlast, obs_tdata, obs_tid, obs_trdy, obs_busy);
         end
      end
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         checks++;
         if (obs_trdy !== '0 || obs_mvalid !== 1'b0 || obs_busy !== 1'b0 ||
             obs_tdata !== '0 || obs_tid !== '0 || obs_mlast !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet: got rdy=%b v=%b busy=%b d=%h, required all 0",
                     obs_trdy, obs_mvalid, obs_busy, obs_tdata);
         end
      end
   endtask

   task automatic test_fairness();
      sel = 1'b0; mode = 0; chk_timing = 1'b1;
      reset_model();
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < NS; s++) push_pkt(s, 2, '0, 1'b1, -1, 0, 0);
      drain(200);
      checks++;
      if (pkt_cnt != 8 || pkt_code[31:0] !== 32'h0123_0123) begin
         failures++;
         $display("FAIL fairness_order: got %0d pkts code=%h, required 8 pkts code=01230123",
                  pkt_cnt, pkt_code[31:0]);
      end
   endtask

   task automatic test_fixed_priority();
      int n = 0;
      sel = 1'b1; mode = 0; chk_timing = 1'b1;
      reset_model();
      for (int p = 0; p < 3; p++) begin
         push_pkt(1, int'($urandom_range(3, 1)), '0, 1'b1, -1, 0, 0);
         push_pkt(3, int'($urandom_range(3, 1)), '0, 1'b1, -1, 0, 0);
      end
      while (drv_q[1].size() != 0 && n < 100) begin
         checks++;
         if (obs_trdy[3] !== 1'b0) begin
            failures++;
            $display("FAIL fixed_starve: got src3 tready=%b while src1 pending, required 0", obs_trdy[3]);
         end
         step();
         n++;
      end
      drain(200);
      checks++;
      if (pkt_cnt != 6 || pkt_code[23:0] !== 24'h111333) begin
         failures++;
         $display("FAIL fixed_order: got %0d pkts code=%h, required 6 pkts code=111333",
                  pkt_cnt, pkt_code[23:0]);
      end
      sel = 1'b0;
   endtask

   task automatic test_atomicity();
      int n = 0;
      sel = 1'b0; mode = 0; chk_timing = 1'b0;
      reset_model();
      push_pkt(2, 5, 32'h2000, 1'b0, 2, 3, 0);
      step();
      push_pkt(0, 3, 32'h0100, 1'b0, -1, 0, 0);
      while (drv_q[2].size() != 0 && n < 100) begin
         checks++;
         if (obs_trdy[0] !== 1'b0) begin
            failures++;
            $display("FAIL atomic_hold: got src0 tready=%b inside src2 packet, required 0", obs_trdy[0]);
         end
         step();
         n++;
      end
      drain(200);
      checks++;
      if (pkt_cnt != 2 || pkt_code[7:0] !== 8'h20 || beats_out != 8) begin
         failures++;
         $display("FAIL atomic_order: got %0d pkts code=%h beats=%0d, required 2 pkts code=20 beats=8",
                  pkt_cnt, pkt_code[7:0], beats_out);
      end
   endtask

   task automatic test_backpressure();
      sel = 1'b0; mode = 1; chk_timing = 1'b0;
      reset_model();
      push_pkt(1, 8, 32'h10, 1'b0, -1, 0, 0);
      drain(200);
      checks++;
      if (pkt_cnt != 1 || pkt_code[3:0] !== 4'h1 || beats_out != 8) begin
         failures++;
         $display("FAIL backpressure_count: got %0d pkts tid=%0d beats=%0d, required 1 pkt tid=1 beats=8",
                  pkt_cnt, pkt_code[3:0], beats_out);
      end
      mode = 0;
   endtask

   task automatic test_lone_single_beat();
      sel = 1'b0; mode = 0; chk_timing = 1'b1;
      reset_model();
      for (int p = 0; p < 3; p++) push_pkt(2, 1, '0, 1'b1, -1, 0, 0);
      drain(100);
      checks++;
      if (pkt_cnt != 3 || pkt_code[11:0] !== 12'h222) begin
         failures++;
         $display("FAIL lone_order: got %0d pkts code=%h, required 3 pkts code=222",
                  pkt_cnt, pkt_code[11:0]);
      end
   endtask

   task automatic test_reset_mid_packet();
      int n = 0;
      sel = 1'b0; mode = 0; chk_timing = 1'b0;
      reset_model();
      push_pkt(3, 6, 32'h3000, 1'b0, -1, 0, 0);
      while (drv_q[3].size() > 4 && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (drv_q[3].size() != 4 || obs_mvalid !== 1'b1 || obs_trdy !== 4'b1000 || obs_busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_pkt_setup: got left=%0d v=%b rdy=%b busy=%b, required left=4 v=1 rdy=1000 busy=1",
                  drv_q[3].size(), obs_mvalid, obs_trdy, obs_busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (obs_mvalid !== 1'b0 || obs_trdy !== '0 || obs_busy !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got v=%b rdy=%b busy=%b, required all 0",
                  obs_mvalid, obs_trdy, obs_busy);
      end
      reset_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      push_pkt(1, 2, 32'h1100, 1'b0, -1, 0, 0);
      push_pkt(3, 2, 32'h3300, 1'b0, -1, 0, 0);
      drain(100);
      checks++;
      if (pkt_cnt != 2 || pkt_code[7:0] !== 8'h13) begin
         failures++;
         $display("FAIL ptr_after_reset: got %0d pkts code=%h, required 2 pkts code=13",
                  pkt_cnt, pkt_code[7:0]);
      end
   endtask

   task automatic test_random();
      int total = 0;
      int len;
      sel = 1'b0; mode = 2; chk_timing = 1'b0;
      reset_model();
      for (int p = 0; p < 40; p++) begin
         len = int'($urandom_range(6, 1));
         total += len;
         push_pkt(int'($urandom_range(NS - 1, 0)), len, '0, 1'b1, -1, 0, 2);
      end
      drain(4000);
      checks++;
      if (pkt_cnt != 40 || beats_out != total) begin
         failures++;
         $display("FAIL random_totals: got %0d pkts %0d beats, required 40 pkts %0d beats",
                  pkt_cnt, beats_out, total);
      end
      mode = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish by time limit, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 1'b0; mode = 0; drv_mrdy = 1'b1; cyc = 0;
      drv_vld = '0; drv_last = '0; drv_data = '0;
      rst = 1'b1;
      #2;
      test_reset();
      test_fairness();
      test_fixed_priority();
      test_atomicity();
      test_backpressure();
      test_lone_single_beat();
      test_reset_mid_packet();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/easy_fifo_axis_rr_arb.md
Name: easy_fifo_axis_rr_arb

Overview:
Packet-atomic N-to-1 AXI-Stream arbiter that shares one sync AXIS FIFO write port between several requesters. It grants one source at a time, holds the grant until that source's tlast beat is accepted, then rotates priority. The output is registered, and the winning source index is emitted as m_axis_tid. It sits directly in front of the sync FIFO wrapper's s_axis port.

Parameters:
DWIDTH, 32, data width per source and output
N_SRC, 4, number of requesters (2..16)
ROUND_ROBIN, 1, 1 = rotating priority starting after the last winner; 0 = fixed priority, lowest index wins
IDW, $clog2(N_SRC), width of m_axis_tid (derived, not overridden)

Ports:
clk  input  1  single clock, all logic posedge
rst  input  1  asynchronous, active-low reset
s_axis_tdata  input  N_SRC*DWIDTH  source i occupies bits [i*DWIDTH +: DWIDTH]
s_axis_tvalid  input  N_SRC  per-source valid
s_axis_tlast  input  N_SRC  per-source end of packet
s_axis_tready  output  N_SRC  per-source ready; at most one bit set
m_axis_tdata  output  DWIDTH  registered output data
m_axis_tvalid  output  1  registered output valid
m_axis_tlast  output  1  registered output last
m_axis_tid  output  IDW  index of the source that produced the beat
m_axis_tready  input  1  downstream ready (FIFO ~full)
busy  output  1  high while in state LOCK

Behaviour:
- Reset (rst=0, async assert; release must be synchronised upstream): state=IDLE, ptr=0, grant=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, busy=0. Reset mid-packet drops the partial packet silently.
- Output register ("slot") loads when slot_free = ~m_axis_tvalid | m_axis_tready. The slot holds its value while m_axis_tvalid=1 and m_axis_tready=0. m_axis_tvalid clears when the slot drains with no new load.
- IDLE: s_axis_tready=0. If any tvalid is set, pick a winner and register it in grant, then go to LOCK the next cycle. With ROUND_ROBIN=1 the winner is the first i with tvalid[i], scanning ptr, ptr+1, ... mod N_SRC. With ROUND_ROBIN=0 the winner is the lowest i with tvalid[i].
- LOCK: s_axis_tready[grant] = slot_free; all other bits are 0. A beat is accepted when tvalid[grant] & tready[grant]. On acceptance the slot loads the data, tlast and tid=grant.
- Exit from LOCK: when the accepted beat has tlast=1, go to IDLE and set ptr <= (grant==N_SRC-1) ? 0 : grant+1. Otherwise stay in LOCK.
- Grant is held across tvalid gaps inside a packet. Other sources are never interleaved.
- Latency: source beat to m_axis_tvalid is 1 cycle. Arbitration costs 1 cycle, so there is one IDLE bubble between packets. Sustained throughput inside a packet is 1 beat/clk while m_axis_tready=1.
- Single-beat packet (tvalid and tlast in the first LOCK cycle): one beat transferred, then back to IDLE.
- Backpressure: m_axis_tready=0 with the slot full forces s_axis_tready to 0. No beat is lost or duplicated.
- Lone requester: with ROUND_ROBIN=1 the same source wins every arbitration. The only cost is the 1-cycle bubble per packet.
- Sources must hold tdata/tvalid/tlast stable until accepted (AXIS rule). The block does not check this.

Decomposition:
- easy_fifo_pkg: typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t; function rr_pick(req, ptr, n), the rotate-and-priority-encode search, returning the index plus a found flag.
- One sub-module, easy_fifo_axis_out_reg: the registered AXIS slot (data, last, tid, valid, slot_free). It is reusable for the FIFO wrapper's OUTPUT_REG path.
- The top holds the FSM, ptr, grant and the tready fan-out.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then released, no tvalid. Expect all outputs 0, busy=0, s_axis_tready=0 indefinitely.
- Fairness: N_SRC=4, all sources continuously offer 2-beat packets. Expect m_axis_tid packet order 0,1,2,3,0,1; each packet's 2 beats contiguous; one bubble cycle between packets.
- Fixed priority: ROUND_ROBIN=0, sources 1 and 3 always valid. Expect tid=1 for every packet; source 3 is never granted.
- Atomicity: src 2 sends a 5-beat packet with a 3-cycle tvalid gap after beat 2, while src 0 is valid throughout. Expect 5 consecutive tid=2 beats with tlast only on beat 5; src 0 is granted next.
- Backpressure: m_axis_tready toggles 1,0,0,1 repeating during an 8-beat packet of data 0x10..0x17. Expect output exactly 0x10..0x17 in order, each beat once, tlast on 0x17, and tdata stable while tready=0.
- Reset mid-packet: assert rst on beat 3 of 6. Expect m_axis_tvalid=0 and s_axis_tready=0 asynchronously (same cycle). After release, arbitration restarts from ptr=0.
